// File: rtl/flash_arb_pkg.sv
// Shared types and default sizing for the flash read arbiter.
// Holds the arbiter FSM state encoding and the default parameter values
// used by flash_read_arbiter and its round-robin picker.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_TIMEOUT   = 15;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request after last_owner.
// Ports: req_i (request vector), last_owner_i (previous owner index),
//        owner_o (selected index), found_o (any request asserted).
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [IDX_W-1:0]   owner_o,
  output logic               found_o
);

  // Scan starts one past the previous owner and wraps, so the previous
  // owner is considered last.
  always_comb begin
    owner_o = '0;
    found_o = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found_o && req_i[(int'(last_owner_i) + i) % NUM_REQ]) begin
        found_o = 1'b1;
        owner_o = IDX_W'((int'(last_owner_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one flash memory controller among NUM_REQ readers,
// with up to MAX_BURST sequential reads per grant and a per-read timeout.
// Ports: clk/rst (sync, active-high); req/base_addr per requester; gnt, rvalid,
//        rerr, rdata, busy to requesters; fmc_start/fmc_addr/fmc_ready/fmc_data to fmc.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] base_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ-1:0]        rerr,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      fmc_start,
  output logic [ADDR_W-1:0]         fmc_addr,
  input  logic                      fmc_ready,
  input  logic [DATA_W-1:0]         fmc_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [BC_W-1:0]     burst_q, burst_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]  rerr_q, rerr_d;

  logic [IDX_W-1:0]    pick_owner;
  logic                pick_found;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (req),
    .last_owner_i (last_q),
    .owner_o      (pick_owner),
    .found_o      (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      cur_addr_q <= '0;
      burst_q    <= '0;
      timer_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
      rerr_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cur_addr_q <= cur_addr_d;
      burst_q    <= burst_d;
      timer_q    <= timer_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cur_addr_d = cur_addr_q;
    burst_d    = burst_q;
    timer_d    = timer_q;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    rerr_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d    = pick_owner;
          cur_addr_d = base_addr[int'(pick_owner)*ADDR_W +: ADDR_W];
          burst_d    = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A completing read takes priority over an expiring timer.
        if (fmc_ready) begin
          rdata_d           = fmc_data;
          rvalid_d[owner_q] = 1'b1;
          burst_d           = burst_q + BC_W'(1);
          if (req[owner_q] && ((int'(burst_q) + 1) < MAX_BURST)) begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            state_d    = ST_ISSUE;
          end else begin
            last_d  = owner_q;
            state_d = ST_IDLE;
          end
        end else if (int'(timer_q) == TIMEOUT - 1) begin
          rerr_d[owner_q] = 1'b1;
          last_d          = owner_q;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state_q != ST_IDLE) gnt[owner_q] = 1'b1;
  end

  assign busy      = (state_q != ST_IDLE);
  assign fmc_start = (state_q == ST_ISSUE);
  assign fmc_addr  = cur_addr_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign rerr      = rerr_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter (2 requesters, burst 4, timeout 15).
// Expected owners, addresses and pulse timing come from a transaction-level model.
module tb_flash_read_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req;
  logic [NR*AW-1:0] base_addr;
  logic [NR-1:0]  gnt, rvalid, rerr;
  logic [DW-1:0]  rdata;
  logic           busy, fmc_start;
  logic [AW-1:0]  fmc_addr;
  logic           fmc_ready;
  logic [DW-1:0]  fmc_data;

  int n_cmp = 0;
  int n_bad = 0;

  flash_read_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr),
    .gnt(gnt), .rvalid(rvalid), .rerr(rerr), .rdata(rdata), .busy(busy),
    .fmc_start(fmc_start), .fmc_addr(fmc_addr),
    .fmc_ready(fmc_ready), .fmc_data(fmc_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first asserted request strictly after the last owner.
  function automatic int rr_next(input logic [NR-1:0] r, input int last);
    for (int i = 1; i <= NR; i++)
      if (r[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Entered with ISSUE visible. Holds fmc_ready low for w WAIT cycles, then
  // completes the read; req[own] is set to keep for the completing edge.
  task automatic read_txn(input int own, input logic [AW-1:0] addr, input int w,
                          input bit keep, input bit noise);
    logic [DW-1:0] d;
    chk("issue_start", fmc_start, 1);
    chk("issue_gnt", gnt, onehot(own));
    chk("issue_addr", fmc_addr, addr);
    step();
    chk("wait_start", fmc_start, 0);
    for (int i = 0; i < w; i++) begin
      if (noise) begin
        req[1-own] = 1'($urandom);
        base_addr  = {$urandom};
      end
      step();
      chk("wait_gnt", gnt, onehot(own));
      chk("wait_addr", fmc_addr, addr);
      chk("wait_rvalid", rvalid, 0);
    end
    req[own]  = keep;
    d         = DW'($urandom);
    fmc_ready = 1'b1;
    fmc_data  = d;
    step();
    fmc_ready = 1'b0;
    fmc_data  = DW'($urandom);
    chk("rvalid", rvalid, onehot(own));
    chk("rdata", rdata, d);
    chk("rerr_none", rerr, 0);
  endtask

  // Runs one grant to completion from the ISSUE cycle; returns burst length.
  task automatic run_grant(input int own, input logic [AW-1:0] base, input int keep_pct,
                           input int wmax, input bit noise, output int nreads);
    int  cnt;
    bit  keep, cont;
    cnt = 0;
    do begin
      keep = ($urandom_range(0, 99) < keep_pct);
      read_txn(own, AW'(base + cnt), $urandom_range(0, wmax), keep, noise);
      cont = keep && (cnt + 1 < MB);
      cnt++;
      chk("busy_after_read", busy, cont);
    end while (cont);
    nreads = cnt;
  endtask

  initial begin
    int last, own, nr;
    logic [NR-1:0] r;
    logic [AW-1:0] b;

    rst = 1'b1; req = '0; base_addr = '0; fmc_ready = 1'b0; fmc_data = '0;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rerr", rerr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", fmc_start, 0);
    chk("rst_addr", fmc_addr, 0);
    rst = 1'b0;
    last = NR - 1;

    // Single read from requester 0, fmc answers 3 cycles after the strobe.
    base_addr[0 +: AW] = 16'h0010;
    req = 2'b01;
    step();
    read_txn(0, 16'h0010, 2, 1'b0, 1'b0);
    chk("single_idle", busy, 0);
    step();
    chk("single_rvalid_once", rvalid, 0);
    chk("single_no_restart", fmc_start, 0);
    last = 0;

    // Both held: whole bursts alternate owners.
    req = 2'b11;
    base_addr = {$urandom};
    for (int g = 0; g < 4; g++) begin
      own = rr_next(req, last);
      chk("alt_owner", own, (g % 2 == 0) ? 1 : 0);
      b = base_addr[own*AW +: AW];
      step();
      run_grant(own, b, 100, 1, 1'b0, nr);
      chk("alt_len", nr, MB);
      last = own;
      req = 2'b11;
    end

    // Address wrap during a burst; requester 0 joins mid-burst and goes next.
    req = 2'b10;
    base_addr[AW +: AW] = 16'hFFFE;
    base_addr[0 +: AW]  = 16'h1234;
    step();
    read_txn(1, 16'hFFFE, 0, 1'b1, 1'b0);
    read_txn(1, 16'hFFFF, 1, 1'b1, 1'b0);
    req[0] = 1'b1;
    read_txn(1, 16'h0000, 0, 1'b1, 1'b0);
    read_txn(1, 16'h0001, 2, 1'b1, 1'b0);
    chk("wrap_release", busy, 0);
    step();
    chk("wrap_next_gnt", gnt, 2'b01);
    read_txn(0, 16'h1234, 0, 1'b0, 1'b0);
    last = 0;
    req = '0;

    // Randomised grants against the round-robin model.
    for (int g = 0; g < 12; g++) begin
      r = NR'($urandom_range(1, 3));
      req = r;
      base_addr = {$urandom};
      own = rr_next(r, last);
      b = base_addr[own*AW +: AW];
      step();
      run_grant(own, b, 70, 5, 1'b1, nr);
      last = own;
      req = '0;
    end

    // Hung fmc: rerr 15 cycles after entering WAIT.
    req = 2'b01;
    step();
    chk("to_gnt", gnt, 2'b01);
    step();
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("to_no_rerr", rerr, 0);
      chk("to_no_rvalid", rvalid, 0);
      chk("to_busy", busy, 1);
    end
    step();
    chk("to_rerr", rerr, 2'b01);
    chk("to_rvalid", rvalid, 0);
    chk("to_busy_off", busy, 0);
    chk("to_gnt_off", gnt, 0);
    req = '0;
    step();
    chk("to_rerr_pulse", rerr, 0);

    // fmc_ready coincides with the timeout cycle: the read wins.
    req = 2'b10;
    base_addr[AW +: AW] = 16'h0ACE;
    step();
    read_txn(1, 16'h0ACE, TO - 1, 1'b0, 1'b0);
    chk("race_idle", busy, 0);
    step();
    chk("race_no_rerr", rerr, 0);

    // Stray fmc_ready while idle.
    fmc_ready = 1'b1;
    step();
    fmc_ready = 1'b0;
    chk("idle_ready_rvalid", rvalid, 0);
    chk("idle_ready_busy", busy, 0);

    // Reset in the middle of WAIT.
    req = 2'b01;
    base_addr[0 +: AW] = 16'h5A5A;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("mrst_gnt", gnt, 0);
    chk("mrst_rvalid", rvalid, 0);
    chk("mrst_rerr", rerr, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_start", fmc_start, 0);
    chk("mrst_addr", fmc_addr, 0);
    rst = 1'b0;
    req = '0;
    fmc_ready = 1'b1;
    fmc_data = 16'hBEEF;
    step();
    fmc_ready = 1'b0;
    chk("mrst_stray_rvalid", rvalid, 0);
    step();
    chk("mrst_stray_rvalid2", rvalid, 0);

    // Priority restarts at requester 0 after reset.
    req = 2'b11;
    step();
    chk("mrst_first_owner", gnt, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
